// File: rtl/lab4_wr_sequencer.sv
// Write-window sequencer for NUM_LAB LAB4 digitizers: rotates a shared window address and holds triggered windows.
// Optional pre-trigger capture (no FROZEN window) is enabled by defining L4_WR_PRETRIG_EN.
module lab4_wr_sequencer #(
  parameter int unsigned NUM_LAB       = 12,
  parameter int unsigned WR_BITS       = 5,
  parameter int unsigned WINDOW_CLOCKS = 8,
  parameter int unsigned HOLD_DEPTH    = 4,
  parameter int unsigned PRETRIG       = 1
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_LAB-1:0]                  lab_en_i,
  input  logic                                trig_i,
  input  logic                                release_i,
  output logic [NUM_LAB*WR_BITS-1:0]          wr_addr_o,
  output logic [NUM_LAB-1:0]                  wr_en_o,
  output logic [WR_BITS-1:0]                  held_addr_o,
  output logic [$clog2(HOLD_DEPTH+1)-1:0]     held_count_o,
  output logic                                empty_o,
  output logic                                full_o,
  output logic                                overflow_o
);

  localparam int unsigned RING  = 1 << WR_BITS;
  localparam int unsigned PH_W  = (WINDOW_CLOCKS > 1) ? $clog2(WINDOW_CLOCKS) : 1;
  localparam int unsigned PTR_W = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(HOLD_DEPTH + 1);

  if (WINDOW_CLOCKS < 2 || HOLD_DEPTH >= RING || PRETRIG >= RING) begin : g_param_err
    $error("lab4_wr_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {WRITE, SKIP, FROZEN} state_t;

  state_t               state_q;
  logic [WR_BITS-1:0]   cur_q;
  logic [PH_W-1:0]      phase_q;
  logic [RING-1:0]      held_q, held_d;
  logic [WR_BITS-1:0]   fifo_q [HOLD_DEPTH];
  logic [PTR_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [WR_BITS-1:0]   held_addr_q, held_addr_d;
  logic                 empty_q, full_q, overflow_q;
  logic [NUM_LAB-1:0]   wr_en_q;

  logic [WR_BITS-1:0]   hold_addr, nxt_addr;
  logic                 trig_ok, pop, push, drop_ovf, freeze, tc, nxt_held;

`ifndef L4_WR_PRETRIG_EN
  logic [WR_BITS-1:0]   last_q;
`endif

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(HOLD_DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  // Trigger/release arbitration and next hold-queue contents
  always_comb begin
`ifdef L4_WR_PRETRIG_EN
    hold_addr = WR_BITS'(cur_q - WR_BITS'(PRETRIG));
    trig_ok   = !held_q[hold_addr];
`else
    hold_addr = (state_q == SKIP) ? last_q : cur_q;
    trig_ok   = (state_q != FROZEN) && !held_q[hold_addr];
`endif
    pop      = release_i && (count_q != '0);
    push     = trig_i && trig_ok && ((count_q != CNT_W'(HOLD_DEPTH)) || pop);
    drop_ovf = trig_i && trig_ok && !push;
`ifdef L4_WR_PRETRIG_EN
    freeze   = 1'b0;
`else
    freeze   = push && (state_q == WRITE);
`endif

    count_d = count_q;
    if (push && !pop)      count_d = CNT_W'(count_q + CNT_W'(1));
    else if (pop && !push) count_d = CNT_W'(count_q - CNT_W'(1));
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;

    held_d = held_q;
    if (pop)  held_d[fifo_q[head_q]] = 1'b0;
    if (push) held_d[hold_addr]      = 1'b1;

    // New head is the pushed address only when the queue drains to nothing first
    if (count_d == '0)
      held_addr_d = '0;
    else if ((count_q == '0) || (pop && count_q == CNT_W'(1)))
      held_addr_d = hold_addr;
    else
      held_addr_d = fifo_q[head_d];

    tc       = (phase_q == PH_W'(WINDOW_CLOCKS - 1));
    nxt_addr = WR_BITS'(cur_q + WR_BITS'(1));
    nxt_held = held_q[nxt_addr];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WRITE;
      cur_q       <= '0;
      phase_q     <= '0;
      held_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      held_addr_q <= '0;
      empty_q     <= 1'b1;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      wr_en_q     <= '0;
      for (int i = 0; i < HOLD_DEPTH; i++) fifo_q[i] <= '0;
`ifndef L4_WR_PRETRIG_EN
      last_q      <= '0;
`endif
    end else begin
      held_q      <= held_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      held_addr_q <= held_addr_d;
      empty_q     <= (count_d == '0);
      full_q      <= (count_d == CNT_W'(HOLD_DEPTH));
      overflow_q  <= overflow_q | drop_ovf;
      if (push) fifo_q[tail_q] <= hold_addr;
`ifndef L4_WR_PRETRIG_EN
      if (state_q == WRITE) last_q <= cur_q;
`endif

      case (state_q)
        WRITE, FROZEN: begin
          if (tc) begin
            phase_q <= '0;
            cur_q   <= nxt_addr;
            if (nxt_held) begin
              state_q <= SKIP;
              wr_en_q <= '0;
            end else begin
              state_q <= WRITE;
              wr_en_q <= lab_en_i;
            end
          end else begin
            phase_q <= PH_W'(phase_q + PH_W'(1));
            if (freeze) begin
              state_q <= FROZEN;
              wr_en_q <= '0;
            end else if (state_q == WRITE) begin
              wr_en_q <= lab_en_i;
            end else begin
              wr_en_q <= '0;
            end
          end
        end
        SKIP: begin
          cur_q   <= nxt_addr;
          phase_q <= '0;
          if (nxt_held) begin
            wr_en_q <= '0;
          end else begin
            state_q <= WRITE;
            wr_en_q <= lab_en_i;
          end
        end
        default: begin
          state_q <= WRITE;
          wr_en_q <= '0;
        end
      endcase
    end
  end

  assign wr_addr_o    = {NUM_LAB{cur_q}};
  assign wr_en_o      = wr_en_q;
  assign held_addr_o  = held_addr_q;
  assign held_count_o = count_q;
  assign empty_o      = empty_q;
  assign full_o       = full_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_lab4_wr_sequencer.sv
// Directed bench for lab4_wr_sequencer; held windows tracked in a scoreboard queue.
module tb_lab4_wr_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [11:0] lab_en_i;
  logic        trig_i;
  logic        release_i;
  logic [59:0] wr_addr_o;
  logic [11:0] wr_en_o;
  logic [4:0]  held_addr_o;
  logic [2:0]  held_count_o;
  logic        empty_o, full_o, overflow_o;

  int n_assert = 0;
  int n_fail   = 0;
  logic [4:0] sb [$];

  lab4_wr_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i), .lab_en_i(lab_en_i), .trig_i(trig_i),
    .release_i(release_i), .wr_addr_o(wr_addr_o), .wr_en_o(wr_en_o),
    .held_addr_o(held_addr_o), .held_count_o(held_count_o), .empty_o(empty_o),
    .full_o(full_o), .overflow_o(overflow_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic logic [59:0] rep(input logic [4:0] a);
    logic [59:0] r;
    for (int i = 0; i < 12; i++) r[i*5 +: 5] = a;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input logic [4:0] a, input logic [11:0] en);
    chk({tag, "_addr"}, 64'(wr_addr_o), 64'(rep(a)));
    chk({tag, "_en"}, 64'(wr_en_o), 64'(en));
  endtask

  task automatic chk_q(input string tag);
    logic [4:0] h;
    h = (sb.size() != 0) ? sb[0] : 5'd0;
    chk({tag, "_cnt"},   64'(held_count_o), 64'(sb.size()));
    chk({tag, "_head"},  64'(held_addr_o), 64'(h));
    chk({tag, "_empty"}, 64'(empty_o), 64'(sb.size() == 0));
    chk({tag, "_full"},  64'(full_o), 64'(sb.size() == 4));
  endtask

  // Advance until the target window first appears, bounded
  task automatic wait_addr(input logic [4:0] a);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (wr_addr_o[4:0] !== a && n < 600);
    chk("wait_addr", 64'(wr_addr_o[4:0]), 64'(a));
  endtask

  task automatic pulse_trig(input logic [4:0] exp_addr);
    trig_i = 1'b1;
    sb.push_back(exp_addr);
    tick();
    trig_i = 1'b0;
  endtask

  task automatic do_release();
    chk("rel_head", 64'(held_addr_o), 64'(sb[0]));
    void'(sb.pop_front());
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; lab_en_i = 12'hFFF; trig_i = 1'b0; release_i = 1'b0;
    tick(); tick();
    chk_win("reset", 5'd0, 12'h000);
    chk_q("reset");
    chk("reset_ovf", 64'(overflow_o), 64'd0);
    rst_i = 1'b0;

    // Free run: one window step every 8 clocks, wrapping at 32
    for (int k = 1; k <= 8 * 33; k++) begin
      tick();
      chk_win("freerun", 5'((k / 8) % 32), 12'hFFF);
    end

    // Trigger at window 5, phase 3
    wait_addr(5'd5);
    tick(); tick(); tick();
    pulse_trig(5'd5);
    chk_win("frozen", 5'd5, 12'h000);
    chk_q("trig5");
    tick(); tick(); tick();
    chk_win("frozen_end", 5'd5, 12'h000);
    tick();
    chk_win("after_frozen", 5'd6, 12'hFFF);

    // Next lap skips window 5 with a single idle clock
    wait_addr(5'd4);
    for (int i = 0; i < 7; i++) tick();
    chk_win("pre_skip", 5'd4, 12'hFFF);
    tick();
    chk_win("skip5", 5'd5, 12'h000);
    tick();
    chk_win("post_skip", 5'd6, 12'hFFF);

    // Hold consecutive windows 7 and 8
    wait_addr(5'd7);
    pulse_trig(5'd7);
    wait_addr(5'd8);
    pulse_trig(5'd8);
    chk_q("hold78");
    wait_addr(5'd6);
    for (int i = 0; i < 7; i++) tick();
    tick();
    chk_win("skip7", 5'd7, 12'h000);
    tick();
    chk_win("skip8", 5'd8, 12'h000);
    tick();
    chk_win("write9", 5'd9, 12'hFFF);

    // Fill the queue, then overflow
    pulse_trig(5'd9);
    chk_q("full");
    wait_addr(5'd10);
    trig_i = 1'b1;
    tick();
    trig_i = 1'b0;
    chk("ovf_set", 64'(overflow_o), 64'd1);
    chk_q("ovf");
    chk_win("ovf_keeps_writing", 5'd10, 12'hFFF);

    // Simultaneous trigger and release while full
    chk("both_head", 64'(held_addr_o), 64'(sb[0]));
    void'(sb.pop_front());
    sb.push_back(5'd10);
    trig_i = 1'b1; release_i = 1'b1;
    tick();
    trig_i = 1'b0; release_i = 1'b0;
    chk_q("both");
    chk("both_ovf", 64'(overflow_o), 64'd1);
    chk("both_en", 64'(wr_en_o), 64'd0);

    // Drain the queue in order
    while (sb.size() != 0) begin
      do_release();
      chk_q("drain");
    end

    // Release while empty is ignored
    release_i = 1'b1;
    tick();
    release_i = 1'b0;
    chk_q("rel_empty");

    // Per-channel enable mask
    wait_addr(5'd11);
    lab_en_i = 12'h0F0;
    tick();
    chk_win("mask", 5'd11, 12'h0F0);
    tick();
    chk_win("mask2", 5'd11, 12'h0F0);
    lab_en_i = 12'hFFF;

    // Reset in the middle of a frozen window with three held
    wait_addr(5'd12);
    pulse_trig(5'd12);
    wait_addr(5'd13);
    pulse_trig(5'd13);
    wait_addr(5'd14);
    pulse_trig(5'd14);
    chk_q("three");
    tick(); tick();
    rst_i = 1'b1;
    tick();
    sb.delete();
    chk_win("midreset", 5'd0, 12'h000);
    chk_q("midreset");
    chk("midreset_ovf", 64'(overflow_o), 64'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk_win("post_reset", 5'd1, 12'hFFF);
    for (int i = 0; i < 8 * 12; i++) tick();
    chk_win("post_reset_13", 5'd13, 12'hFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/lab4_wr_sequencer.md
Name: lab4_wr_sequencer

Overview:
- Parametrised write-window sequencer for NUM_LAB LAB4 digitizers. It generalises the fixed 12-channel, 5-bit L4x_WR / L4x_WR_EN pin set.
- Steps a shared storage-window address around a ring of 2^WR_BITS windows.
- On trigger, it freezes the active window out of rotation, queues it for readout, and returns it to the ring when readout logic releases it.
- Sits between the trigger/HOLD logic and the per-LAB write-address pins in the top level.

Parameters:
- NUM_LAB, 12, number of LAB4 channels driven.
- WR_BITS, 5, width of the window address; the ring holds 2^WR_BITS windows.
- WINDOW_CLOCKS, 8, clk_i cycles per window (≥2).
- HOLD_DEPTH, 4, max simultaneously held windows; must be < 2^WR_BITS.
- PRETRIG, 1, windows back from current to hold (used only with the optional feature).

Ports:
- clk_i, in, 1, sequencer clock.
- rst_i, in, 1, reset, synchronous, active-high.
- lab_en_i, in, NUM_LAB, per-channel write enable mask.
- trig_i, in, 1, single-cycle trigger pulse.
- release_i, in, 1, single-cycle pulse; pops the oldest held window.
- wr_addr_o, out, NUM_LAB*WR_BITS, per-LAB window address; channel k is at bits [k*WR_BITS +: WR_BITS].
- wr_en_o, out, NUM_LAB, per-LAB write enable.
- held_addr_o, out, WR_BITS, oldest held window (head of the queue).
- held_count_o, out, clog2(HOLD_DEPTH+1), number of held windows.
- empty_o, out, 1, held_count_o == 0.
- full_o, out, 1, held_count_o == HOLD_DEPTH.
- overflow_o, out, 1, sticky flag: a trigger was dropped because the queue was full.

Behaviour:
- Clock and reset:
  - One clock, clk_i.
  - rst_i is synchronous, active-high.
  - While rst_i is high, the reset values are: cur_addr=0, phase counter=0, wr_en_o=0, wr_addr_o=0, held bitmap all clear, queue empty, held_count_o=0, empty_o=1, full_o=0, overflow_o=0, held_addr_o=0.
  - Reset mid-operation discards every held window.
- Window stepping:
  - The phase counter runs 0..WINDOW_CLOCKS-1.
  - At terminal count it wraps to 0 and cur_addr advances to cur_addr+1 mod 2^WR_BITS.
- Skipping held windows:
  - If the candidate address is set in the held bitmap, the sequencer enters SKIP.
  - In SKIP it spends one clk per held address, incrementing with wr_en_o=0, until it reaches an unheld address.
  - It then enters WRITE with the phase counter at 0.
- State machine, states WRITE, SKIP and FROZEN:
  - WRITE: wr_en_o = lab_en_i. On terminal count, go to WRITE or SKIP per the held bitmap.
  - FROZEN: entered on an accepted trigger. wr_en_o=0 for the remainder of the window. The phase counter keeps running; at terminal count, advance as in WRITE.
  - SKIP: wr_en_o=0. Exits to WRITE on the first unheld address.
- Registered outputs:
  - wr_addr_o replicates cur_addr to every channel, all fields registered.
  - wr_en_o is registered and lags the state by 0 cycles.
  - Deasserting lab_en_i[k] drops wr_en_o[k] on the next clock.
- Trigger:
  - trig_i at cycle N with the queue not full: held address = cur_addr.
  - At N+1: the bitmap bit is set, the address is pushed to the queue tail, held_count_o increments, and wr_en_o=0 (FROZEN).
  - A trigger during SKIP holds the last written address (the previous WRITE address), not the skip candidate.
  - A trigger during FROZEN is ignored.
  - A trigger while full is dropped and sets overflow_o at N+1. overflow_o clears only on rst_i.
- Release:
  - release_i with the queue not empty pops the head and clears its bitmap bit at N+1.
  - release_i while empty is ignored.
- Simultaneous trig_i and release_i:
  - Both are processed in the same cycle; held_count_o is unchanged.
  - When full, the release frees a slot and the trigger is accepted, with no overflow.
- held_addr_o is valid only when empty_o=0, and is otherwise 0.
- Guarantee: because HOLD_DEPTH < 2^WR_BITS, at least one address is unheld, so SKIP terminates within HOLD_DEPTH clocks.

Optional Feature:
- Macro: L4_WR_PRETRIG_EN.
- Defined: the held address is (cur_addr − PRETRIG) mod 2^WR_BITS, so the windows preceding the trigger are captured.
  - The current window keeps writing (no FROZEN state).
  - If that address is already held, the trigger is dropped without setting overflow.
- Undefined: the held address is cur_addr, with FROZEN behaviour as above, and the PRETRIG parameter is unused.

Test Plan:
- Reset then free-run, with WINDOW_CLOCKS=8, WR_BITS=5, lab_en_i all ones → wr_addr_o steps 0,1,…,31,0 every 8 clocks; wr_en_o stays all ones.
- trig_i while cur_addr=5, phase=3 → next clock wr_en_o=0, held_count_o=1, held_addr_o=5. Address 6 starts 4 clocks later. On the following wrap, address 5 is skipped: 4→6, with one wr_en_o=0 cycle.
- Hold addresses 7 and 8 (consecutive) → after window 6 there are two SKIP clocks with wr_en_o=0, then address 9 writes.
- Fill the queue with 4 triggers, then a 5th trig_i → overflow_o=1 and held_count_o stays 4. Then assert trig_i and release_i together → count stays 4, the head advances, and the new address joins the tail.
- release_i while empty, and lab_en_i=12'h0F0 → count stays 0; only wr_en_o[7:4] assert.
- Assert rst_i mid-FROZEN with 3 windows held → next clock: count 0, empty_o=1, overflow_o=0, wr_addr_o=0, wr_en_o=0.
